sprite_loc_ctrl: RTL and testbench

- Parametrised grid-position controller for one maze sprite (Pac-Man or ghost).
- Generalises fixed 40x30 Pac-Man control with:
  - configurable map size and start tile
  - rate-limited stepping
  - buffered turn input (cornering): try requested turn first, fall back to current heading
  - explicit collision-lookup handshake
  - edge tunnel wrap
- Sits between input/AI logic, the map-RAM collision lookup and the RAM write/erase module.

---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_loc_ctrl_grid_step.sv | 65 ++++++
 rtl/sprite_loc_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sprite_loc_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite grid-position controller.
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RETRY  = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic [3:0] COLL_WALL = 4'h1;

endpackage

// File: rtl/sprite_loc_ctrl_grid_step.sv
// One-tile step of a grid position in a given direction.
// Build option TUNNEL_WRAP_EN: horizontal edges wrap around (tunnel);
// without it every edge step is flagged off_edge. Vertical edges are
// always flagged off_edge.
module grid_step
    import sprite_pkg::*;
#(
    parameter int X_W   = 6,
    parameter int Y_W   = 5,
    parameter int MAP_W = 40,
    parameter int MAP_H = 30
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  dir_t           dir,
    output logic [X_W-1:0] nx,
    output logic [Y_W-1:0] ny,
    output logic           off_edge
);

    localparam logic [X_W-1:0] X_MAX = X_W'(MAP_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(MAP_H - 1);
    localparam logic [X_W-1:0] X_ONE = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

    // Candidate position; off_edge leaves the position unchanged.
    always_comb begin
        nx       = x;
        ny       = y;
        off_edge = 1'b0;
        case (dir)
            DIR_UP: begin
                if (y == '0) off_edge = 1'b1;
                else         ny = y - Y_ONE;
            end
            DIR_DOWN: begin
                if (y == Y_MAX) off_edge = 1'b1;
                else            ny = y + Y_ONE;
            end
            DIR_LEFT: begin
                if (x == '0) begin
`ifdef TUNNEL_WRAP_EN
                    nx = X_MAX;
`else
                    off_edge = 1'b1;
`endif
                end else begin
                    nx = x - X_ONE;
                end
            end
            DIR_RIGHT: begin
                if (x == X_MAX) begin
`ifdef TUNNEL_WRAP_EN
                    nx = '0;
`else
                    off_edge = 1'b1;
`endif
                end else begin
                    nx = x + X_ONE;
                end
            end
        endcase
    end

endmodule

// File: rtl/sprite_loc_ctrl.sv
// Grid-position controller for one maze sprite: rate-limited stepping,
// buffered turns with fallback to the current heading, collision lookup
// handshake and RAM-writer handshake. Build option TUNNEL_WRAP_EN enables
// horizontal tunnel wrap (see grid_step).
//
//   state  | meaning
//   IDLE   | waiting for a step tick; next mirrors curr
//   LOOKUP | req high, waiting for coll_valid on next_x/next_y
//   RETRY  | turn hit a wall; next re-aimed along heading, one idle cycle
//   WRITE  | ready high, waiting for the RAM writer's done
module sprite_loc_ctrl
    import sprite_pkg::*;
#(
    parameter int X_W         = 6,
    parameter int Y_W         = 5,
    parameter int MAP_W       = 40,
    parameter int MAP_H       = 30,
    parameter int START_X     = 20,
    parameter int START_Y     = 20,
    parameter int MOVE_PERIOD = 2500000
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           up,
    input  logic           down,
    input  logic           left,
    input  logic           right,
    input  logic           coll_valid,
    input  logic [3:0]     collision_type,
    input  logic           done,
    output logic [X_W-1:0] curr_x,
    output logic [Y_W-1:0] curr_y,
    output logic [X_W-1:0] next_x,
    output logic [Y_W-1:0] next_y,
    output logic           req,
    output logic           ready,
    output dir_t           heading,
    output logic           moving
);

    localparam int             CNT_W    = $clog2(MOVE_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    state_t           state, state_n;
    logic [X_W-1:0]   curr_x_n, next_x_n, step_x;
    logic [Y_W-1:0]   curr_y_n, next_y_n, step_y;
    dir_t             heading_n, pend_dir, pend_dir_n, att_dir, att_dir_n;
    dir_t             in_dir, first_dir, step_dir;
    logic             moving_n, pend_valid, pend_valid_n, att_pend, att_pend_n;
    logic             in_valid, step_off;

    // Free-running step-rate counter; ticks outside IDLE are simply missed.
    always_ff @(posedge CLOCK_50) begin
        if (reset || cnt == CNT_LAST) cnt <= '0;
        else                          cnt <= cnt + CNT_W'(1);
    end

    assign tick = (cnt == CNT_LAST);

    grid_step #(
        .X_W  (X_W),
        .Y_W  (Y_W),
        .MAP_W(MAP_W),
        .MAP_H(MAP_H)
    ) u_step (
        .x       (curr_x),
        .y       (curr_y),
        .dir     (step_dir),
        .nx      (step_x),
        .ny      (step_y),
        .off_edge(step_off)
    );

    // State and datapath registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            curr_x     <= X_W'(START_X);
            curr_y     <= Y_W'(START_Y);
            next_x     <= X_W'(START_X);
            next_y     <= Y_W'(START_Y);
            heading    <= DIR_LEFT;
            moving     <= 1'b0;
            pend_valid <= 1'b0;
            pend_dir   <= DIR_LEFT;
            att_dir    <= DIR_LEFT;
            att_pend   <= 1'b0;
        end else begin
            state      <= state_n;
            curr_x     <= curr_x_n;
            curr_y     <= curr_y_n;
            next_x     <= next_x_n;
            next_y     <= next_y_n;
            heading    <= heading_n;
            moving     <= moving_n;
            pend_valid <= pend_valid_n;
            pend_dir   <= pend_dir_n;
            att_dir    <= att_dir_n;
            att_pend   <= att_pend_n;
        end
    end

    // Next-state logic: input capture, attempt selection and handshakes.
    always_comb begin
        state_n      = state;
        curr_x_n     = curr_x;
        curr_y_n     = curr_y;
        next_x_n     = next_x;
        next_y_n     = next_y;
        heading_n    = heading;
        moving_n     = moving;
        pend_valid_n = pend_valid;
        pend_dir_n   = pend_dir;
        att_dir_n    = att_dir;
        att_pend_n   = att_pend;
        req          = (state == LOOKUP);
        ready        = (state == WRITE);

        in_valid = up | down | left | right;
        if (up)        in_dir = DIR_UP;
        else if (down) in_dir = DIR_DOWN;
        else if (left) in_dir = DIR_LEFT;
        else           in_dir = DIR_RIGHT;

        first_dir = pend_valid ? pend_dir : heading;
        // IDLE probes the first attempt; later states only ever step along heading.
        step_dir  = (state == IDLE) ? first_dir : heading;

        if (in_valid) begin
            pend_valid_n = 1'b1;
            pend_dir_n   = in_dir;
        end

        case (state)
            IDLE: begin
                next_x_n = curr_x;
                next_y_n = curr_y;
                if (tick && (pend_valid || moving)) begin
                    att_dir_n  = first_dir;
                    att_pend_n = pend_valid;
                    if (!step_off) begin
                        next_x_n = step_x;
                        next_y_n = step_y;
                        state_n  = LOOKUP;
                    end else if (pend_valid && pend_dir != heading && moving) begin
                        // Edge counts as a wall; RETRY aims next along heading.
                        att_dir_n  = heading;
                        att_pend_n = 1'b0;
                        state_n    = RETRY;
                    end else begin
                        moving_n = 1'b0;
                    end
                end
            end
            LOOKUP: begin
                if (coll_valid) begin
                    if (collision_type != COLL_WALL) begin
                        heading_n = att_dir;
                        moving_n  = 1'b1;
                        if (att_pend && pend_valid && pend_dir == att_dir && !in_valid)
                            pend_valid_n = 1'b0;
                        state_n = WRITE;
                    end else if (att_pend && att_dir != heading && moving) begin
                        next_x_n   = step_x;
                        next_y_n   = step_y;
                        att_dir_n  = heading;
                        att_pend_n = 1'b0;
                        state_n    = RETRY;
                    end else begin
                        moving_n = 1'b0;
                        next_x_n = curr_x;
                        next_y_n = curr_y;
                        state_n  = IDLE;
                    end
                end
            end
            RETRY: begin
                if (step_off) begin
                    moving_n = 1'b0;
                    next_x_n = curr_x;
                    next_y_n = curr_y;
                    state_n  = IDLE;
                end else begin
                    next_x_n = step_x;
                    next_y_n = step_y;
                    state_n  = LOOKUP;
                end
            end
            WRITE: begin
                if (done) begin
                    curr_x_n = next_x;
                    curr_y_n = next_y;
                    state_n  = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_loc_ctrl.sv
// Directed bench for sprite_loc_ctrl (MOVE_PERIOD = 4). Expected probe
// positions are queued when a move is scripted and popped when req appears.
module tb_sprite_loc_ctrl;
    import sprite_pkg::*;

    localparam logic [3:0] P_NONE  = 4'b0000;
    localparam logic [3:0] P_UP    = 4'b1000;
    localparam logic [3:0] P_DOWN  = 4'b0100;
    localparam logic [3:0] P_LEFT  = 4'b0010;
    localparam logic [3:0] P_RIGHT = 4'b0001;
    localparam logic [3:0] C_PASS  = 4'h0;
    localparam logic [3:0] C_WALL  = 4'h1;

    logic       CLOCK_50 = 1'b0;
    logic       reset, up, down, left, right, coll_valid, done;
    logic [3:0] collision_type;
    logic [5:0] curr_x, next_x;
    logic [4:0] curr_y, next_y;
    logic       req, ready, moving;
    dir_t       heading;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        int y;
    } pos_t;
    pos_t exp_q[$];

    sprite_loc_ctrl #(.MOVE_PERIOD(4)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .up            (up),
        .down          (down),
        .left          (left),
        .right         (right),
        .coll_valid    (coll_valid),
        .collision_type(collision_type),
        .done          (done),
        .curr_x        (curr_x),
        .curr_y        (curr_y),
        .next_x        (next_x),
        .next_y        (next_y),
        .req           (req),
        .ready         (ready),
        .heading       (heading),
        .moving        (moving)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [3:0] p);
        {up, down, left, right} = p;
        @(negedge CLOCK_50);
        {up, down, left, right} = P_NONE;
    endtask

    // Watch n cycles: no lookup request and no ready may appear.
    task automatic idle_watch(input int n, input string tag);
        bit seen_req, seen_ready;
        seen_req   = 1'b0;
        seen_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            seen_req   |= req;
            seen_ready |= ready;
        end
        chk({tag, "_no_req"}, {31'b0, seen_req}, 0);
        chk({tag, "_no_ready"}, {31'b0, seen_ready}, 0);
    endtask

    // Serve one lookup at (ex,ey); on pass, optionally press a direction
    // during WRITE, then either finish with done or reset mid-WRITE.
    task automatic do_move(input int ex, input int ey, input logic [3:0] ctype,
                           input logic [3:0] pr, input bit rst_w, input dir_t hd);
        pos_t p;
        int   n;
        p.x = ex;
        p.y = ey;
        exp_q.push_back(p);
        n = 0;
        while (req !== 1'b1 && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        p = exp_q.pop_front();
        chk("req_seen", {31'b0, req}, 1);
        if (req !== 1'b1) return;
        chk("probe_x", {26'b0, next_x}, p.x);
        chk("probe_y", {27'b0, next_y}, p.y);
        chk("ready_in_lookup", {31'b0, ready}, 0);
        coll_valid     = 1'b1;
        collision_type = ctype;
        @(negedge CLOCK_50);
        coll_valid     = 1'b0;
        collision_type = 4'h0;
        chk("req_drop", {31'b0, req}, 0);
        if (ctype == C_WALL) begin
            chk("ready_after_wall", {31'b0, ready}, 0);
            return;
        end
        chk("ready_rise", {31'b0, ready}, 1);
        {up, down, left, right} = pr;
        @(negedge CLOCK_50);
        {up, down, left, right} = P_NONE;
        chk("ready_hold", {31'b0, ready}, 1);
        if (rst_w) begin
            reset = 1'b1;
            @(negedge CLOCK_50);
            reset = 1'b0;
            chk("rst_ready", {31'b0, ready}, 0);
            chk("rst_req", {31'b0, req}, 0);
            chk("rst_curr_x", {26'b0, curr_x}, 20);
            chk("rst_curr_y", {27'b0, curr_y}, 20);
            chk("rst_next_x", {26'b0, next_x}, 20);
            chk("rst_moving", {31'b0, moving}, 0);
            return;
        end
        done = 1'b1;
        @(negedge CLOCK_50);
        done = 1'b0;
        chk("commit_x", {26'b0, curr_x}, ex);
        chk("commit_y", {27'b0, curr_y}, ey);
        chk("ready_fall", {31'b0, ready}, 0);
        chk("heading", {30'b0, heading}, {30'b0, hd});
        chk("moving", {31'b0, moving}, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {up, down, left, right} = P_NONE;
        coll_valid     = 1'b0;
        collision_type = 4'h0;
        done           = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;

        // Reset state and quiet idle
        @(negedge CLOCK_50);
        chk("reset_curr_x", {26'b0, curr_x}, 20);
        chk("reset_curr_y", {27'b0, curr_y}, 20);
        chk("reset_next_x", {26'b0, next_x}, 20);
        chk("reset_next_y", {27'b0, next_y}, 20);
        chk("reset_heading", {30'b0, heading}, {30'b0, DIR_LEFT});
        idle_watch(12, "reset_idle");
        chk("reset_moving", {31'b0, moving}, 0);

        // Pulse up, then auto-step up to (20,10), turning left there
        pulse(P_UP);
        do_move(20, 19, C_PASS, P_NONE, 1'b0, DIR_UP);
        for (int y = 18; y >= 10; y--)
            do_move(20, y, C_PASS, (y == 10) ? P_LEFT : P_NONE, 1'b0, DIR_UP);
        for (int x = 19; x >= 4; x--)
            do_move(x, 10, C_PASS, (x == 4) ? P_RIGHT : P_NONE, 1'b0, DIR_LEFT);

        // Moving right at (5,10), buffered up hits a wall, fall back right
        do_move(5, 10, C_PASS, P_UP, 1'b0, DIR_RIGHT);
        do_move(5, 9, C_WALL, P_NONE, 1'b0, DIR_RIGHT);
        do_move(6, 10, C_PASS, P_NONE, 1'b0, DIR_RIGHT);
        do_move(6, 9, C_PASS, P_LEFT, 1'b0, DIR_UP);

        // Moving left, wall with nothing pending: stop in place
        do_move(5, 9, C_PASS, P_NONE, 1'b0, DIR_LEFT);
        do_move(4, 9, C_WALL, P_NONE, 1'b0, DIR_LEFT);
        chk("stop_next_x", {26'b0, next_x}, 5);
        chk("stop_next_y", {27'b0, next_y}, 9);
        chk("stop_moving", {31'b0, moving}, 0);
        idle_watch(12, "stopped");

        // Down to row 12, then left to the edge
        pulse(P_DOWN);
        for (int y = 10; y <= 12; y++)
            do_move(5, y, C_PASS, (y == 12) ? P_LEFT : P_NONE, 1'b0, DIR_DOWN);
        for (int x = 4; x >= 0; x--)
            do_move(x, 12, C_PASS, P_NONE, 1'b0, DIR_LEFT);

`ifdef TUNNEL_WRAP_EN
        do_move(39, 12, C_PASS, P_NONE, 1'b0, DIR_LEFT);
        do_move(38, 12, C_PASS, P_NONE, 1'b1, DIR_LEFT);
`else
        idle_watch(12, "edge_auto");
        chk("edge_moving", {31'b0, moving}, 0);
        chk("edge_next_x", {26'b0, next_x}, 0);
        chk("edge_next_y", {27'b0, next_y}, 12);
        pulse(P_LEFT);
        idle_watch(12, "edge_press");
        chk("edge_press_moving", {31'b0, moving}, 0);
        pulse(P_RIGHT);
        do_move(1, 12, C_PASS, P_NONE, 1'b1, DIR_RIGHT);
`endif

        // After the mid-WRITE reset nothing is pending or moving
        idle_watch(12, "post_reset");
        chk("post_reset_curr_x", {26'b0, curr_x}, 20);
        chk("post_reset_heading", {30'b0, heading}, {30'b0, DIR_LEFT});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
